// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: default operand
// width, iteration counter width and the controller state encoding.
package shift_add_multiplier_pkg;

  localparam int MUL_WIDTH   = 32;
  localparam int MUL_COUNT_W = $clog2(MUL_WIDTH + 1);

  typedef enum logic {
    BUSY = 1'b0,
    DONE = 1'b1
  } mul_state_e;

endpackage

// File: rtl/shift_add_multiplier_product_reg.sv
// Product register of the shift-and-add multiplier. Holds 2*WIDTH+1 bits:
// the low half starts out as the multiplier and is consumed one bit per
// iteration, while the high half accumulates partial sums. The extra top
// bit is where the adder carry lands before the right shift moves it down.
module mul_product_reg #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  input  logic [WIDTH:0]     sum_i,
  output logic [2*WIDTH:0]   prod_o
);

  logic [2*WIDTH:0] prod_q, prod_d;
  logic [2*WIDTH:0] preShift;

  // Place the new partial sum (carry included) into the top slice, then shift right by one
  always_comb begin
    preShift = {sum_i, prod_q[WIDTH-1:0]};
    prod_d   = prod_q;
    if (load_i) begin
      prod_d = {{(WIDTH+1){1'b0}}, multiplier_i};
    end else if (shift_i) begin
      prod_d = {1'b0, preShift[2*WIDTH:1]};
    end
  end

  // Product register update; load wins over shift, otherwise hold
  always_ff @(posedge clk) begin
    prod_q <= prod_d;
  end

  assign prod_o = prod_q;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one shift-and-add iteration per enabled
// clock edge, WIDTH iterations per product. Reset loads new operands and
// restarts; Ready rises on the edge that performs the final iteration.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               Run,
  input  logic [WIDTH-1:0]   Multiplicand_in,
  input  logic [WIDTH-1:0]   Multiplier_in,
  output logic [2*WIDTH-1:0] Product_out,
  output logic               Ready
);

  localparam int CountW = $clog2(WIDTH + 1);
  localparam logic [CountW-1:0] LastIter = CountW'(WIDTH - 1);

  mul_state_e        state_q, state_d;
  logic [CountW-1:0] count_q, count_d;
  logic              ready_q, ready_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;

  logic              loadProd;
  logic              shiftProd;
  logic [WIDTH:0]    sum;
  logic [2*WIDTH:0]  prodQ;
  logic              unusedCarry;

  // Partial-sum adder: upper product half plus multiplicand when the current multiplier bit is set
  always_comb begin
    sum = {1'b0, prodQ[2*WIDTH-1:WIDTH]} + (prodQ[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  end

  // Controller: next state, counter, done flag and product register commands
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ready_d   = ready_q;
    mcand_d   = mcand_q;
    loadProd  = 1'b0;
    shiftProd = 1'b0;
    if (Reset) begin
      state_d  = BUSY;
      count_d  = '0;
      ready_d  = 1'b0;
      mcand_d  = Multiplicand_in;
      loadProd = 1'b1;
    end else begin
      case (state_q)
        BUSY: begin
          if (Run) begin
            shiftProd = 1'b1;
            count_d   = count_q + 1'b1;
            if (count_q == LastIter) begin
              state_d = DONE;
              ready_d = 1'b1;
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = BUSY;
        end
      endcase
    end
  end

  // Controller state registers
  always_ff @(posedge clk) begin
    state_q <= state_d;
    count_q <= count_d;
    ready_q <= ready_d;
    mcand_q <= mcand_d;
  end

  mul_product_reg #(
    .WIDTH(WIDTH)
  ) u_product_reg (
    .clk          (clk),
    .load_i       (loadProd),
    .shift_i      (shiftProd),
    .multiplier_i (Multiplier_in),
    .sum_i        (sum),
    .prod_o       (prodQ)
  );

  // The stored top bit is always zero after a shift; it only exists mid-iteration
  assign unusedCarry = prodQ[2*WIDTH];
  assign Product_out = prodQ[2*WIDTH-1:0];
  assign Ready       = ready_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for the shift-and-add multiplier.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_shift_add_multiplier;

  logic        clk;
  logic        Reset;
  logic        Run;
  logic [31:0] Multiplicand_in;
  logic [31:0] Multiplier_in;
  logic [63:0] Product_out;
  logic        Ready;

  int checkCount;
  int errorCount;

  shift_add_multiplier #(
    .WIDTH(32)
  ) dut (
    .clk             (clk),
    .Reset           (Reset),
    .Run             (Run),
    .Multiplicand_in (Multiplicand_in),
    .Multiplier_in   (Multiplier_in),
    .Product_out     (Product_out),
    .Ready           (Ready)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Load operands with a one-cycle reset pulse, then leave Run high
  task automatic applyStimulus(input logic [31:0] mcand, input logic [31:0] mult);
    @(negedge clk);
    Reset           = 1'b1;
    Run             = 1'b0;
    Multiplicand_in = mcand;
    Multiplier_in   = mult;
    @(negedge clk);
    Reset = 1'b0;
    Run   = 1'b1;
  endtask

  // Count rising edges until Ready, bounded so a stuck design still ends
  task automatic runUntilReady(output int edges);
    edges = 0;
    while (Ready !== 1'b1 && edges < 200) begin
      @(negedge clk);
      edges++;
    end
  endtask

  // Loaded state and the first iteration of 3 x 5
  task automatic test_reset;
    applyStimulus(32'd3, 32'd5);
    checkCount++;
    if (Product_out !== 64'd5) begin
      errorCount++;
      $display("[TB] FAIL reset_product got %h expected %h", Product_out, 64'd5);
    end
    checkCount++;
    if (Ready !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_ready got %b expected 0", Ready);
    end
    @(negedge clk);
    checkCount++;
    if (Product_out !== 64'h0000_0001_8000_0002) begin
      errorCount++;
      $display("[TB] FAIL first_iter got %h expected %h", Product_out, 64'h0000_0001_8000_0002);
    end
  endtask

  // Plain product with exact latency
  task automatic test_basic;
    int edges;
    applyStimulus(32'd3, 32'd5);
    runUntilReady(edges);
    checkCount++;
    if (edges !== 32) begin
      errorCount++;
      $display("[TB] FAIL basic_latency got %0d expected 32", edges);
    end
    checkCount++;
    if (Product_out !== 64'd15) begin
      errorCount++;
      $display("[TB] FAIL basic_product got %h expected %h", Product_out, 64'd15);
    end
  endtask

  // Largest operands exercise the adder carry on every iteration
  task automatic test_carry;
    int edges;
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runUntilReady(edges);
    checkCount++;
    if (edges !== 32) begin
      errorCount++;
      $display("[TB] FAIL carry_latency got %0d expected 32", edges);
    end
    checkCount++;
    if (Product_out !== 64'hFFFF_FFFE_0000_0001) begin
      errorCount++;
      $display("[TB] FAIL carry_product got %h expected %h", Product_out, 64'hFFFF_FFFE_0000_0001);
    end
  endtask

  // Zero in either operand position
  task automatic test_zero;
    int edges;
    applyStimulus(32'd0, 32'h1234_5678);
    runUntilReady(edges);
    checkCount++;
    if (Product_out !== 64'd0 || Ready !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL zero_mcand got %h ready %b expected 0 ready 1", Product_out, Ready);
    end
    applyStimulus(32'h1234_5678, 32'd0);
    runUntilReady(edges);
    checkCount++;
    if (Product_out !== 64'd0 || Ready !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL zero_mult got %h ready %b expected 0 ready 1", Product_out, Ready);
    end
  endtask

  // Run dropped for five cycles after iteration 10 stretches latency to 37 edges
  task automatic test_stall;
    int edges;
    applyStimulus(32'd1000, 32'd1000);
    repeat (10) @(negedge clk);
    Run = 1'b0;
    repeat (5) @(negedge clk);
    checkCount++;
    if (Product_out !== 64'h0000_03D0_9000_0000 || Ready !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL stall_hold got %h ready %b expected %h ready 0", Product_out, Ready, 64'h0000_03D0_9000_0000);
    end
    Run = 1'b1;
    runUntilReady(edges);
    checkCount++;
    if (edges + 15 !== 37) begin
      errorCount++;
      $display("[TB] FAIL stall_latency got %0d expected 37", edges + 15);
    end
    checkCount++;
    if (Product_out !== 64'd1000000) begin
      errorCount++;
      $display("[TB] FAIL stall_product got %h expected %h", Product_out, 64'd1000000);
    end
  endtask

  // Reset at iteration 16 with Run still high restarts on new operands
  task automatic test_restart;
    int edges;
    applyStimulus(32'h0000_ABCD, 32'h0000_1234);
    repeat (16) @(negedge clk);
    Reset           = 1'b1;
    Multiplicand_in = 32'd7;
    Multiplier_in   = 32'd6;
    @(negedge clk);
    Reset = 1'b0;
    checkCount++;
    if (Ready !== 1'b0 || Product_out !== 64'd6) begin
      errorCount++;
      $display("[TB] FAIL restart_load got %h ready %b expected %h ready 0", Product_out, Ready, 64'd6);
    end
    runUntilReady(edges);
    checkCount++;
    if (edges !== 32 || Product_out !== 64'd42) begin
      errorCount++;
      $display("[TB] FAIL restart_result got %h after %0d edges expected %h after 32", Product_out, edges, 64'd42);
    end
  endtask

  // In DONE, Run toggling and operand changes leave the result alone
  task automatic test_hold;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      Run             = ~Run;
      Multiplicand_in = 32'h1111_1111 * (i + 1);
      Multiplier_in   = 32'h0F0F_0F0F + i;
      checkCount++;
      if (Product_out !== 64'd42 || Ready !== 1'b1) begin
        errorCount++;
        $display("[TB] FAIL hold_cycle%0d got %h ready %b expected %h ready 1", i, Product_out, Ready, 64'd42);
      end
    end
  endtask

  // Reset from DONE followed directly by a new product
  task automatic test_back_to_back;
    int edges;
    applyStimulus(32'd2, 32'd9);
    checkCount++;
    if (Ready !== 1'b0 || Product_out !== 64'd9) begin
      errorCount++;
      $display("[TB] FAIL b2b_load got %h ready %b expected %h ready 0", Product_out, Ready, 64'd9);
    end
    runUntilReady(edges);
    checkCount++;
    if (edges !== 32 || Product_out !== 64'd18) begin
      errorCount++;
      $display("[TB] FAIL b2b_result got %h after %0d edges expected %h after 32", Product_out, edges, 64'd18);
    end
  endtask

  // Test sequence and summary
  initial begin
    checkCount      = 0;
    errorCount      = 0;
    Reset           = 1'b0;
    Run             = 1'b0;
    Multiplicand_in = '0;
    Multiplier_in   = '0;
    $display("[TB] starting shift_add_multiplier tests");
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_stall();
    test_restart();
    test_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
